// File: rtl/shift_unit_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encoding and
// the amount-saturation rule.
package shift_unit_pipe_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_mode_e;

  // Rotates wrap their amount; every other mode saturates once amount >= WIDTH.
  function automatic logic mode_saturates(shift_mode_e mode);
    return mode != SHIFT_ROR;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_layer.sv
// One barrel layer: optionally shifts/rotates by a fixed distance DIST.
module shift_layer
  import shift_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  shift_mode_e      mode_i,
  input  logic             sign_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    if (enable_i) begin
      unique case (mode_i)
        SHIFT_SLL: data_o = data_i << DIST;
        SHIFT_SRL: data_o = data_i >> DIST;
        SHIFT_SRA: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
        SHIFT_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
        default:   data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter, one register stage per barrel layer, with
// valid/ready on both sides and a combinational back-to-front ready chain.
module shift_unit_pipe
  import shift_unit_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [AMT_W-1:0] IN_AMT,
  input  logic [1:0]       IN_MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_ZERO
);

  localparam int unsigned L = $clog2(WIDTH);

  shift_mode_e in_mode;
  logic        in_sat;

  // Stage registers, index 1..L.
  logic [L:1]       vld_q;
  logic [WIDTH-1:0] data_q [1:L];
  shift_mode_e      mode_q [1:L];
  logic [L-1:0]     amt_q  [1:L];
  logic             sat_q  [1:L];
  logic             sign_q [1:L];
  logic             zero_q;

  // What each stage would capture: the upstream stage or, for stage 1, the request.
  logic [L:1]       p_vld;
  logic [WIDTH-1:0] p_data [1:L];
  shift_mode_e      p_mode [1:L];
  logic [L-1:0]     p_amt  [1:L];
  logic             p_sat  [1:L];
  logic             p_sign [1:L];
  logic [WIDTH-1:0] layer_out [1:L];
  logic [WIDTH-1:0] data_d    [1:L];
  logic [L:1]       ld;

  // Saturation is resolved once at the input; ROR simply keeps amount mod WIDTH.
  assign in_mode = shift_mode_e'(IN_MODE);
  assign in_sat  = mode_saturates(in_mode) && (IN_AMT >= AMT_W'(WIDTH));

  // A stage loads when empty or when the stage after it is moving.
  always_comb begin
    ld    = '0;
    ld[L] = !vld_q[L] || OUT_READY;
    for (int i = L - 1; i >= 1; i--) begin
      ld[i] = !vld_q[i] || ld[i+1];
    end
  end

  assign IN_READY  = ld[1];
  assign OUT_VALID = vld_q[L];
  assign OUT_DATA  = data_q[L];
  assign OUT_ZERO  = zero_q;

  for (genvar i = 1; i <= L; i++) begin : g_stage
    if (i == 1) begin : g_head
      assign p_vld[i]  = IN_VALID;
      assign p_data[i] = IN_DATA;
      assign p_mode[i] = in_mode;
      assign p_amt[i]  = IN_AMT[L-1:0];
      assign p_sat[i]  = in_sat;
      assign p_sign[i] = IN_DATA[WIDTH-1];
    end else begin : g_body
      assign p_vld[i]  = vld_q[i-1];
      assign p_data[i] = data_q[i-1];
      assign p_mode[i] = mode_q[i-1];
      assign p_amt[i]  = amt_q[i-1];
      assign p_sat[i]  = sat_q[i-1];
      assign p_sign[i] = sign_q[i-1];
    end

    shift_layer #(
      .WIDTH (WIDTH),
      .DIST  (1 << (i - 1))
    ) u_layer (
      .data_i   (p_data[i]),
      .mode_i   (p_mode[i]),
      .sign_i   (p_sign[i]),
      .enable_i (p_amt[i][i-1]),
      .data_o   (layer_out[i])
    );

    // The last stage overrides the barrel result with the saturated value.
    if (i == L) begin : g_sat
      assign data_d[i] = !p_sat[i]                ? layer_out[i]      :
                         (p_mode[i] == SHIFT_SRA) ? {WIDTH{p_sign[i]}} : '0;
    end else begin : g_pass
      assign data_d[i] = layer_out[i];
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        vld_q[i]  <= 1'b0;
        data_q[i] <= '0;
        mode_q[i] <= SHIFT_SLL;
        amt_q[i]  <= '0;
        sat_q[i]  <= 1'b0;
        sign_q[i] <= 1'b0;
      end else if (ld[i]) begin
        vld_q[i] <= p_vld[i];
        if (p_vld[i]) begin
          data_q[i] <= data_d[i];
          mode_q[i] <= p_mode[i];
          amt_q[i]  <= p_amt[i];
          sat_q[i]  <= p_sat[i];
          sign_q[i] <= p_sign[i];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      zero_q <= 1'b1;
    end else if (ld[L] && p_vld[L]) begin
      zero_q <= (data_d[L] == '0);
    end
  end

endmodule
